// File: rtl/dmem_map_pkg.sv
// Address map and status-word layout shared by the data-memory responder.
// Word-address decode is done once here so every consumer agrees on the map.
package dmem_map_pkg;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    localparam logic [1:0] OFF_CYCLE = 2'd0;
    localparam logic [1:0] OFF_LED   = 2'd1;
    localparam logic [1:0] OFF_FIFO  = 2'd2;
    localparam logic [1:0] OFF_DROPS = 2'd3;

    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_COUNT_LSB = 4;
    localparam int unsigned STAT_COUNT_W   = 5;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_LED,
        SEL_FIFO,
        SEL_DROPS
    } sel_e;

    // RAM wins first; the MMIO page is the four words starting at MMIO_BASE.
    function automatic sel_e decode_addr(input logic [31:0] addr, input int unsigned depth);
        sel_e s;
        s = SEL_NONE;
        if (addr < 32'(depth)) begin
            s = SEL_RAM;
        end else if (addr[31:2] == MMIO_BASE[31:2]) begin
            case (addr[1:0])
                OFF_CYCLE: s = SEL_CYCLE;
                OFF_LED:   s = SEL_LED;
                OFF_FIFO:  s = SEL_FIFO;
                default:   s = SEL_DROPS;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory port plus LED and output-stream signals of the responder.
interface dmem_responder_if #(
    parameter int unsigned LED_W = 16
);
    logic [31:0]      address_dmem;
    logic [31:0]      data;
    logic             wren;
    logic [31:0]      q_dmem;
    logic [LED_W-1:0] leds;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;

    modport master (
        output address_dmem, data, wren, out_ready,
        input  q_dmem, leds, out_valid, out_data
    );

    modport slave (
        input  address_dmem, data, wren, out_ready,
        output q_dmem, leds, out_valid, out_data
    );
endinterface

// File: rtl/dmem_responder_out_fifo.sv
// Synchronous output FIFO; accepts a push while full only when a pop frees a slot
// in the same cycle, and reports rejected pushes as drop.
module out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          drop
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign pop_ok  = pop_req && !empty;
    assign push_ok = push_req && (!full || pop_ok);
    assign drop    = push_req && full && !pop_ok;

    // Head is forced to zero when empty so storage never leaks X to the output.
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PW'(1);
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO page (cycle counter, LEDs,
// output FIFO with status and saturating drop counter), one-cycle registered reads.
module dmem_responder
    import dmem_map_pkg::*;
#(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LED_W      = 16
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram [DEPTH];
    logic [AW-1:0]    ram_idx;
    sel_e             sel;
    logic             wr_en;

    logic [31:0]      cycle_cnt;
    logic [LED_W-1:0] leds_q;
    logic [15:0]      drops;
    logic [31:0]      q_reg;
    logic [31:0]      fifo_status;

    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      fifo_head;

    assign sel       = decode_addr(bus.address_dmem, DEPTH);
    assign ram_idx   = bus.address_dmem[AW-1:0];
    assign wr_en     = bus.wren && !reset;
    assign fifo_push = wr_en && (sel == SEL_FIFO);

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32),
        .CW    (CW)
    ) u_out_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_req (fifo_push),
        .pop_req  (bus.out_ready),
        .wdata    (bus.data),
        .rdata    (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .drop     (fifo_drop)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head;
    assign bus.leds      = leds_q;
    assign bus.q_dmem    = q_reg;

    always_comb begin
        fifo_status = '0;
        fifo_status[STAT_FULL_BIT]  = fifo_full;
        fifo_status[STAT_EMPTY_BIT] = fifo_empty;
        fifo_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    end

    // RAM has no reset; writes during reset are already masked by wr_en.
    always_ff @(posedge clock) begin
        if (wr_en && (sel == SEL_RAM)) begin
            ram[ram_idx] <= bus.data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            leds_q    <= '0;
            drops     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_en && (sel == SEL_LED)) begin
                leds_q <= bus.data[LED_W-1:0];
            end
            if (fifo_drop && (drops != '1)) begin
                drops <= drops + 16'd1;
            end
        end
    end

    // All sources are sampled pre-edge, so RAM read-during-write returns old data
    // while LED/FIFO status written last cycle are already visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            case (sel)
                SEL_RAM:   q_reg <= ram[ram_idx];
                SEL_CYCLE: q_reg <= cycle_cnt;
                SEL_LED:   q_reg <= 32'(leds_q);
                SEL_FIFO:  q_reg <= fifo_status;
                SEL_DROPS: q_reg <= 32'(drops);
                default:   q_reg <= '0;
            endcase
        end
    end

endmodule
